// File: rtl/uart_fifo_core.sv
// UART core: TX/RX FIFOs, runtime divisor, optional parity, 1/2 stop bits,
// sticky RX error status and maskable level interrupts behind a register port.
module uart_fifo_core #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int DEF_DIV  = 868,
    parameter int AW       = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    output logic [31:0]   rdata_o,
    output logic          error_o,
    output logic          tx_o,
    input  logic          rx_i,
    output logic          intr_tx_o,
    output logic          intr_rx_o,
    output logic          intr_err_o
);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int RPW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    logic [4:0]  r_ctrl;
    logic [15:0] r_baud;
    logic [2:0]  r_ien;
    logic [7:0]  r_wm;
    logic        r_ovr, r_perr, r_ferr;
    logic        r_intr_tx, r_intr_rx, r_intr_err;

    logic w_a_ctrl, w_a_baud, w_a_txd, w_a_rxd, w_a_stat, w_a_ien, w_a_wm, w_mapped;
    assign w_a_ctrl = addr_i == AW'(32'h00);
    assign w_a_baud = addr_i == AW'(32'h04);
    assign w_a_txd  = addr_i == AW'(32'h08);
    assign w_a_rxd  = addr_i == AW'(32'h0C);
    assign w_a_stat = addr_i == AW'(32'h10);
    assign w_a_ien  = addr_i == AW'(32'h14);
    assign w_a_wm   = addr_i == AW'(32'h18);
    assign w_mapped = w_a_ctrl | w_a_baud | w_a_txd | w_a_rxd | w_a_stat | w_a_ien | w_a_wm;
    assign error_o  = (re_i | we_i) & ~w_mapped;

    logic [15:0] w_div;
    assign w_div = (r_baud < 16'd4) ? 16'd4 : r_baud;

    // ---------------- TX FIFO + serializer ----------------
    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [TPW-1:0] r_tx_wp, r_tx_rp;
    logic [TPW:0]   r_tx_lvl;
    logic           w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_start, w_tx_last;

    state_e      r_tx_st, w_tx_st_n;
    logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_sh, w_tx_sh_n;
    logic        r_tx_pen, r_tx_par, r_tx_stop2;

    assign w_tx_full  = r_tx_lvl == (TPW+1)'(TX_DEPTH);
    assign w_tx_empty = r_tx_lvl == '0;
    assign w_tx_push  = we_i & w_a_txd & be_i[0] & (~w_tx_full | w_tx_pop);
    assign w_tx_start = r_ctrl[0] & ~w_tx_empty;
    assign w_tx_last  = r_tx_cnt == r_tx_div - 16'd1;

    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata_i[7:0];
    end

    always_comb begin
        w_tx_st_n  = r_tx_st;
        w_tx_cnt_n = r_tx_cnt + 16'd1;
        w_tx_bit_n = r_tx_bit;
        w_tx_sh_n  = r_tx_sh;
        w_tx_pop   = 1'b0;
        case (r_tx_st)
            S_IDLE: begin
                w_tx_cnt_n = '0;
                if (w_tx_start) begin
                    w_tx_pop  = 1'b1;
                    w_tx_st_n = S_START;
                end
            end
            S_START: if (w_tx_last) begin
                w_tx_cnt_n = '0;
                w_tx_st_n  = S_DATA;
            end
            S_DATA: if (w_tx_last) begin
                w_tx_cnt_n = '0;
                w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
                w_tx_bit_n = r_tx_bit + 3'd1;
                if (r_tx_bit == 3'd7) w_tx_st_n = r_tx_pen ? S_PAR : S_STOP;
            end
            S_PAR: if (w_tx_last) begin
                w_tx_cnt_n = '0;
                w_tx_st_n  = S_STOP;
            end
            S_STOP: if (w_tx_last) begin
                w_tx_cnt_n = '0;
                // bit counter is idle here, so it marks the first of two stop bits
                if (r_tx_stop2 && r_tx_bit == 3'd0) begin
                    w_tx_bit_n = 3'd1;
                end else begin
                    w_tx_bit_n = '0;
                    if (w_tx_start) begin
                        w_tx_pop  = 1'b1;
                        w_tx_st_n = S_START;
                    end else begin
                        w_tx_st_n = S_IDLE;
                    end
                end
            end
            default: w_tx_st_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_st <= S_IDLE;  r_tx_cnt <= '0;   r_tx_bit <= '0;  r_tx_sh <= '0;
            r_tx_div <= 16'd4;  r_tx_pen <= 1'b0; r_tx_par <= 1'b0; r_tx_stop2 <= 1'b0;
            r_tx_wp <= '0;      r_tx_rp <= '0;    r_tx_lvl <= '0;
        end else begin
            r_tx_st  <= w_tx_st_n;
            r_tx_cnt <= w_tx_cnt_n;
            r_tx_bit <= w_tx_bit_n;
            r_tx_sh  <= w_tx_sh_n;
            if (w_tx_pop) begin
                r_tx_sh    <= r_tx_mem[r_tx_rp];
                r_tx_div   <= w_div;
                r_tx_pen   <= r_ctrl[3] ^ r_ctrl[2];
                r_tx_par   <= (^r_tx_mem[r_tx_rp]) ^ (r_ctrl[3:2] == 2'b10);
                r_tx_stop2 <= r_ctrl[4];
                r_tx_rp    <= r_tx_rp + TPW'(1);
            end
            if (w_tx_push) r_tx_wp <= r_tx_wp + TPW'(1);
            r_tx_lvl <= r_tx_lvl + (TPW+1)'(w_tx_push) - (TPW+1)'(w_tx_pop);
        end
    end

    always_comb begin
        case (r_tx_st)
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = r_tx_sh[0];
            S_PAR:   tx_o = r_tx_par;
            default: tx_o = 1'b1;
        endcase
    end

    // ---------------- RX deserializer + FIFO ----------------
    logic           r_rx_s1, r_rx_s2, r_rx_s3;
    state_e         r_rx_st, w_rx_st_n;
    logic [15:0]    r_rx_cnt, w_rx_cnt_n, r_rx_div;
    logic [2:0]     r_rx_bit, w_rx_bit_n;
    logic [7:0]     r_rx_sh, w_rx_sh_n;
    logic           r_rx_pen, r_rx_podd, r_rx_pbit, w_rx_pbit_n;
    logic           w_rx_go, w_rx_done, w_rx_last, w_rx_pbad, w_rx_good;
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [RPW-1:0] r_rx_wp, r_rx_rp;
    logic [RPW:0]   r_rx_lvl;
    logic           w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

    assign w_rx_last = r_rx_cnt == r_rx_div - 16'd1;

    always_comb begin
        w_rx_st_n   = r_rx_st;
        w_rx_cnt_n  = r_rx_cnt + 16'd1;
        w_rx_bit_n  = r_rx_bit;
        w_rx_sh_n   = r_rx_sh;
        w_rx_pbit_n = r_rx_pbit;
        w_rx_go     = 1'b0;
        w_rx_done   = 1'b0;
        case (r_rx_st)
            S_IDLE: begin
                w_rx_cnt_n = '0;
                w_rx_bit_n = '0;
                if (r_ctrl[1] && r_rx_s3 && !r_rx_s2) begin
                    w_rx_go   = 1'b1;
                    w_rx_st_n = S_START;
                end
            end
            // half-bit wait puts every later sample mid-bit
            S_START: if (r_rx_cnt == (r_rx_div >> 1) - 16'd1) begin
                w_rx_cnt_n = '0;
                w_rx_st_n  = r_rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rx_last) begin
                w_rx_cnt_n = '0;
                w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
                w_rx_bit_n = r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) w_rx_st_n = r_rx_pen ? S_PAR : S_STOP;
            end
            S_PAR: if (w_rx_last) begin
                w_rx_cnt_n  = '0;
                w_rx_pbit_n = r_rx_s2;
                w_rx_st_n   = S_STOP;
            end
            S_STOP: if (w_rx_last) begin
                w_rx_done = 1'b1;
                w_rx_st_n = S_IDLE;
            end
            default: w_rx_st_n = S_IDLE;
        endcase
    end

    assign w_rx_full  = r_rx_lvl == (RPW+1)'(RX_DEPTH);
    assign w_rx_empty = r_rx_lvl == '0;
    assign w_rx_pop   = re_i & w_a_rxd & ~w_rx_empty;
    assign w_rx_pbad  = r_rx_pen & (^r_rx_sh ^ r_rx_pbit ^ r_rx_podd);
    assign w_rx_good  = w_rx_done & r_rx_s2 & ~w_rx_pbad;
    assign w_rx_push  = w_rx_good & (~w_rx_full | w_rx_pop);

    always_ff @(posedge clk_i) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_s1 <= 1'b1;   r_rx_s2 <= 1'b1;   r_rx_s3 <= 1'b1;
            r_rx_st <= S_IDLE; r_rx_cnt <= '0;    r_rx_bit <= '0;   r_rx_sh <= '0;
            r_rx_div <= 16'd4; r_rx_pen <= 1'b0;  r_rx_podd <= 1'b0; r_rx_pbit <= 1'b0;
            r_rx_wp <= '0;     r_rx_rp <= '0;     r_rx_lvl <= '0;
        end else begin
            r_rx_s1   <= rx_i;
            r_rx_s2   <= r_rx_s1;
            r_rx_s3   <= r_rx_s2;
            r_rx_st   <= w_rx_st_n;
            r_rx_cnt  <= w_rx_cnt_n;
            r_rx_bit  <= w_rx_bit_n;
            r_rx_sh   <= w_rx_sh_n;
            r_rx_pbit <= w_rx_pbit_n;
            if (w_rx_go) begin
                r_rx_div  <= w_div;
                r_rx_pen  <= r_ctrl[3] ^ r_ctrl[2];
                r_rx_podd <= r_ctrl[3:2] == 2'b10;
            end
            if (w_rx_push) r_rx_wp <= r_rx_wp + RPW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RPW'(1);
            r_rx_lvl <= r_rx_lvl + (RPW+1)'(w_rx_push) - (RPW+1)'(w_rx_pop);
        end
    end

    // ---------------- registers, status, interrupts ----------------
    logic       w_wr, w_clr;
    logic [7:0] w_wm_eff;
    assign w_wr     = we_i & be_i[0];
    assign w_clr    = w_wr & w_a_stat;
    assign w_wm_eff = (r_wm == 8'd0) ? 8'd1 : r_wm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl <= '0; r_baud <= 16'(DEF_DIV); r_ien <= '0; r_wm <= 8'd1;
            r_ovr <= 1'b0; r_perr <= 1'b0; r_ferr <= 1'b0;
            r_intr_tx <= 1'b0; r_intr_rx <= 1'b0; r_intr_err <= 1'b0;
        end else begin
            if (w_wr && w_a_ctrl) r_ctrl <= wdata_i[4:0];
            if (w_wr && w_a_baud) r_baud[7:0] <= wdata_i[7:0];
            if (we_i && be_i[1] && w_a_baud) r_baud[15:8] <= wdata_i[15:8];
            if (w_wr && w_a_ien) r_ien <= wdata_i[2:0];
            if (w_wr && w_a_wm)  r_wm  <= wdata_i[7:0];
            r_ovr  <= (w_rx_good & w_rx_full & ~w_rx_pop) | (r_ovr & ~(w_clr & wdata_i[5]));
            r_perr <= (w_rx_done & r_rx_s2 & w_rx_pbad) | (r_perr & ~(w_clr & wdata_i[6]));
            r_ferr <= (w_rx_done & ~r_rx_s2) | (r_ferr & ~(w_clr & wdata_i[7]));
            r_intr_tx  <= r_ien[0] & w_tx_empty & (r_tx_st == S_IDLE);
            r_intr_rx  <= r_ien[1] & (16'(r_rx_lvl) >= 16'(w_wm_eff));
            r_intr_err <= r_ien[2] & (r_ovr | r_perr | r_ferr);
        end
    end

    assign intr_tx_o  = r_intr_tx;
    assign intr_rx_o  = r_intr_rx;
    assign intr_err_o = r_intr_err;

    always_comb begin
        rdata_o = '0;
        if (re_i) begin
            if (w_a_ctrl)      rdata_o = {27'd0, r_ctrl};
            else if (w_a_baud) rdata_o = {16'd0, r_baud};
            else if (w_a_rxd)  rdata_o = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rp]};
            else if (w_a_stat) rdata_o = {8'd0, 8'(r_rx_lvl), 8'(r_tx_lvl), r_ferr, r_perr, r_ovr,
                                          r_tx_st == S_IDLE, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
            else if (w_a_ien)  rdata_o = {29'd0, r_ien};
            else if (w_a_wm)   rdata_o = {24'd0, r_wm};
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: queue-based TX line model checked every cycle, plus
// directed loopback, overrun, frame/parity error, glitch, full-FIFO and reset cases.
module tb_uart_fifo_core;
    logic        clk_i = 1'b0, rst_ni = 1'b0, re_i = 1'b0, we_i = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] rdata_o;
    logic        error_o, tx_o, rx_i, intr_tx_o, intr_rx_o, intr_err_o;
    logic        loop = 1'b0, rx_drv = 1'b1, chk_on = 1'b0;
    int          n_tests = 0, n_fail = 0;

    assign rx_i = loop ? tx_o : rx_drv;
    always #5 clk_i = ~clk_i;

    uart_fifo_core #(.TX_DEPTH(16), .RX_DEPTH(16), .DEF_DIV(868), .AW(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .re_i(re_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_o), .error_o(error_o),
        .tx_o(tx_o), .rx_i(rx_i), .intr_tx_o(intr_tx_o), .intr_rx_o(intr_rx_o),
        .intr_err_o(intr_err_o));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic mapped(input logic [7:0] a);
        return a inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
    endfunction

    // model: register copies, TX FIFO as a byte queue, line as a queue of per-clock bit values
    logic [4:0]   m_ctrl;
    logic [15:0]  m_baud;
    logic [2:0]   m_ien;
    logic [7:0]   m_wm;
    byte unsigned m_txq[$];
    bit           m_line[$];
    logic         m_intr_tx;

    task automatic push_bits(input bit b, input int n);
        repeat (n) m_line.push_back(b);
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_ctrl = '0; m_baud = 16'd868; m_ien = '0; m_wm = 8'd1;
            m_txq.delete(); m_line.delete(); m_intr_tx = 1'b0;
        end else begin
            int   old_sz, div;
            bit   m_pop;
            logic nx_intr;
            logic [7:0] d;
            old_sz  = m_txq.size();
            nx_intr = m_ien[0] && old_sz == 0 && m_line.size() == 0;
            if (m_line.size() != 0) void'(m_line.pop_front());
            m_pop = m_line.size() == 0 && m_ctrl[0] && old_sz > 0;
            if (m_pop) begin
                d   = m_txq.pop_front();
                div = (m_baud < 16'd4) ? 4 : int'(m_baud);
                push_bits(1'b0, div);
                for (int i = 0; i < 8; i++) push_bits(d[i], div);
                if (m_ctrl[3:2] == 2'b01) push_bits(^d, div);
                if (m_ctrl[3:2] == 2'b10) push_bits(~^d, div);
                push_bits(1'b1, div);
                if (m_ctrl[4]) push_bits(1'b1, div);
            end
            if (we_i && addr_i == 8'h08 && be_i[0] && (old_sz < 16 || m_pop)) m_txq.push_back(wdata_i[7:0]);
            if (we_i && be_i[0] && addr_i == 8'h00) m_ctrl = wdata_i[4:0];
            if (we_i && be_i[0] && addr_i == 8'h04) m_baud[7:0] = wdata_i[7:0];
            if (we_i && be_i[1] && addr_i == 8'h04) m_baud[15:8] = wdata_i[15:8];
            if (we_i && be_i[0] && addr_i == 8'h14) m_ien = wdata_i[2:0];
            if (we_i && be_i[0] && addr_i == 8'h18) m_wm = wdata_i[7:0];
            m_intr_tx = nx_intr;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni && chk_on) begin
            logic [31:0] st;
            check("tx_o", tx_o, (m_line.size() != 0) ? 64'(m_line[0]) : 64'd1);
            check("intr_tx_o", intr_tx_o, m_intr_tx);
            if (re_i || we_i) check("error_o", error_o, !mapped(addr_i));
            if (re_i) begin
                st = '0;
                st[15:8] = 8'(m_txq.size());
                st[4] = m_line.size() == 0;
                st[1] = m_txq.size() == 0;
                st[0] = m_txq.size() == 16;
                case (addr_i)
                    8'h00: check("rd_ctrl", rdata_o, {27'd0, m_ctrl});
                    8'h04: check("rd_baud", rdata_o, {16'd0, m_baud});
                    8'h10: check("rd_status_tx", rdata_o & 32'h0000FF13, st);
                    8'h14: check("rd_intr_en", rdata_o, {29'd0, m_ien});
                    8'h18: check("rd_rx_wm", rdata_o, {24'd0, m_wm});
                    default: if (!mapped(addr_i)) check("rd_unmapped", rdata_o, 0);
                endcase
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk_i); #1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
        @(posedge clk_i); #1; we_i = 1'b0; be_i = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic e);
        @(posedge clk_i); #1; re_i = 1'b1; addr_i = a;
        @(negedge clk_i); d = rdata_o; e = error_o;
        @(posedge clk_i); #1; re_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_stat(input logic [31:0] mask, input logic [31:0] val, input int n, input string name);
        logic [31:0] d;
        logic e;
        int k = 0;
        do begin rd(8'h10, d, e); k++; end while ((d & mask) != val && k < n);
        check(name, d & mask, val);
    endtask

    task automatic send_bit(input logic b, input int n);
        @(posedge clk_i); #1; rx_drv = b;
        repeat (n - 1) @(posedge clk_i);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop, input int div);
        send_bit(1'b0, div);
        for (int i = 0; i < 8; i++) send_bit(d[i], div);
        if (pen) send_bit(pbit, div);
        send_bit(stop, div);
        send_bit(1'b1, 2 * div);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [9:0]  pat;
        logic [39:0] cap, exp40;
        int          k;
        idle(3);
        rst_ni = 1'b1;
        chk_on = 1'b1;
        check("rst_tx_o", tx_o, 1);
        check("rst_intr", {intr_tx_o, intr_rx_o, intr_err_o}, 0);
        rd(8'h04, d, e); check("rst_baud", d, 32'h364);
        rd(8'h10, d, e); check("rst_status", d, 32'h1A);
        rd(8'h18, d, e); check("rst_rx_wm", d, 32'h1);

        // single 0xA5 frame at 4 clocks per bit
        wr(8'h04, 32'd4, 4'hF); wr(8'h00, 32'h1, 4'hF); wr(8'h08, 32'hA5, 4'hF);
        k = 0;
        while (tx_o !== 1'b0 && k < 20) begin @(negedge clk_i); k++; end
        check("a5_start_seen", k < 20, 1);
        pat = 10'b0101001011;
        for (int i = 0; i < 40; i++) begin
            exp40[39-i] = pat[9 - i/4];
            cap[39-i] = tx_o;
            @(negedge clk_i);
        end
        check("a5_frame", cap, exp40);
        check("a5_after_idle", tx_o, 1);
        check("a5_intr_tx_masked", intr_tx_o, 0);
        wr(8'h14, 32'h1, 4'hF); idle(2);
        check("intr_tx_enabled", intr_tx_o, 1);
        wr(8'h14, 32'h0, 4'hF);

        // loopback, even parity, 16 bytes
        loop = 1'b1;
        wr(8'h04, 32'd8, 4'hF); wr(8'h14, 32'h2, 4'hF); wr(8'h00, 32'h7, 4'hF);
        for (int i = 0; i < 16; i++) wr(8'h08, i, 4'hF);
        wait_stat(32'h00FF0000, 32'h00100000, 2500, "lb_rx_level16");
        rd(8'h10, d, e); check("lb_status_rx", d & 32'h000000EC, 32'h04);
        check("lb_intr_rx", intr_rx_o, 1);
        for (int i = 0; i < 16; i++) begin rd(8'h0C, d, e); check("lb_rxdata", d, i); end
        idle(2);
        check("lb_intr_rx_low", intr_rx_o, 0);
        rd(8'h0C, d, e); check("rx_empty_read", d, 0);

        // overrun: 17 frames, no reads
        wr(8'h14, 32'h4, 4'hF);
        for (int i = 0; i < 17; i++) wr(8'h08, 32'h30 + i, 4'hF);
        wait_stat(32'h20, 32'h20, 2500, "ovr_set");
        wait_stat(32'h12, 32'h12, 500, "ovr_tx_done");
        rd(8'h10, d, e); check("ovr_status", d & 32'h00FF00EC, 32'h00100024);
        check("ovr_intr_err", intr_err_o, 1);
        for (int i = 0; i < 16; i++) begin rd(8'h0C, d, e); check("ovr_rxdata", d, 32'h30 + i); end
        wr(8'h10, 32'h20, 4'hF);
        rd(8'h10, d, e); check("ovr_cleared", d & 32'h00FF00E8, 32'h08);
        idle(2); check("ovr_intr_err_low", intr_err_o, 0);

        // frame error, parity error, glitch, then a clean manual frame
        loop = 1'b0; rx_drv = 1'b1;
        rx_frame(8'h55, 1'b1, 1'b0, 1'b0, 8); idle(3);
        rd(8'h10, d, e); check("ferr_status", d & 32'h00FF00E0, 32'h80);
        check("ferr_intr_err", intr_err_o, 1);
        wr(8'h10, 32'h80, 4'hF);
        rx_frame(8'h0F, 1'b1, 1'b1, 1'b1, 8); idle(3);
        rd(8'h10, d, e); check("perr_status", d & 32'h00FF00E0, 32'h40);
        wr(8'h10, 32'h40, 4'hF);
        wr(8'h04, 32'd16, 4'hF);
        @(posedge clk_i); #1; rx_drv = 1'b0;
        idle(2); rx_drv = 1'b1;
        idle(40);
        rd(8'h10, d, e); check("glitch_status", d & 32'h00FF00E8, 32'h08);
        rx_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16); idle(3);
        rd(8'h0C, d, e); check("manual_rxdata", d, 32'h3C);

        // TX FIFO fill with tx disabled, unmapped access
        wr(8'h00, 32'h0, 4'hF);
        for (int i = 0; i < 17; i++) wr(8'h08, 32'h60 + i, 4'hF);
        rd(8'h10, d, e); check("txfull_status", d & 32'h0000FF13, 32'h1011);
        rd(8'h40, d, e); check("unmapped_rdata", d, 0); check("unmapped_error", e, 1);
        wr(8'h40, 32'hFFFF_FFFF, 4'hF);

        // reset in the middle of a frame
        wr(8'h00, 32'h1, 4'hF); idle(30);
        #3; rst_ni = 1'b0;
        #1; check("rst_mid_tx_o", tx_o, 1);
        @(posedge clk_i); #1; rst_ni = 1'b1;
        rd(8'h10, d, e); check("rst_mid_status", d, 32'h1A);

        // divisor below 4 and partial byte enables
        wr(8'h04, 32'd1, 4'hF);
        rd(8'h04, d, e); check("baud_raw_1", d, 32'h1);
        wr(8'h00, 32'h1, 4'hF); wr(8'h08, 32'h81, 4'hF); idle(60);
        wr(8'h04, 32'h0000_1234, 4'b0010);
        rd(8'h04, d, e); check("baud_be", d, 32'h1201);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
